// File: rtl/bsg_util_tag_trace_depacketizer.sv
// rtl/bsg_util_tag_trace_depacketizer.sv - tag-trace wormhole endpoint: packet to trace word, 2-flit ack back
module bsg_util_tag_trace_depacketizer #(
   parameter int flit_width_p = 8,
   parameter int cord_width_p = 4,
   parameter int len_width_p  = 4,
   parameter int data_flits_p = 4
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic [flit_width_p+1:0]              link_i,
   output logic [flit_width_p+1:0]              link_o,
   output logic                                 trace_v_o,
   output logic [data_flits_p*flit_width_p-1:0] trace_data_o,
   input  logic                                 trace_ready_i,
   output logic [7:0]                           err_count_o
);

   localparam int link_width_lp = flit_width_p + 2;
   localparam int idx_width_lp  = (data_flits_p > 1) ? $clog2(data_flits_p) : 1;

   localparam logic [len_width_p-1:0]  exp_len_lp  = len_width_p'(data_flits_p + 1);
   localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(data_flits_p - 1);

   typedef enum logic [2:0] {
      S_HDR, S_SRC, S_DATA, S_DRAIN, S_OUT, S_ACK_HDR, S_ACK_ST
   } state_e;

   state_e                    state, state_n;
   logic                      rdy_r, v_r, trace_v_r, err_r;
   logic [flit_width_p-1:0]   data_r;
   logic [cord_width_p-1:0]   src_cord_r, ack_cord;
   logic [len_width_p-1:0]    rem_r;
   logic [idx_width_lp-1:0]   idx_r;
   logic [data_flits_p*flit_width_p-1:0] trace_data_r;
   logic [7:0]                err_count_r;

   // Link unpacking: {v, data, ready_and_rev}
   logic                      in_v, out_ready;
   logic [flit_width_p-1:0]   in_data;
   logic [len_width_p-1:0]    in_len;
   logic [cord_width_p-1:0]   in_cord;

   assign in_v      = link_i[link_width_lp-1];
   assign in_data   = link_i[flit_width_p:1];
   assign out_ready = link_i[0];
   assign in_len    = in_data[cord_width_p +: len_width_p];
   assign in_cord   = in_data[cord_width_p-1:0];

   logic accept, send, trace_fire;
   assign accept     = in_v & rdy_r;
   assign send       = v_r & out_ready;
   assign trace_fire = trace_v_r & trace_ready_i;

   // A malformed header jumps straight to the ack, so the cord must not come from a previous packet
   assign ack_cord = (state == S_HDR) ? '0 : src_cord_r;

   // Next-state decode; all outputs are registered from this in the block below
   always_comb begin
      state_n = state;
      case (state)
         S_HDR: begin
            if (accept) begin
               if (in_len == exp_len_lp)   state_n = S_SRC;
               else if (in_len == '0)      state_n = S_ACK_HDR;
               else                        state_n = S_DRAIN;
            end
         end
         S_SRC:     if (accept) state_n = S_DATA;
         S_DATA:    if (accept && idx_r == last_idx_lp) state_n = S_OUT;
         S_DRAIN:   if (accept && rem_r == len_width_p'(1)) state_n = S_ACK_HDR;
         S_OUT:     if (trace_fire) state_n = S_ACK_HDR;
         S_ACK_HDR: if (send) state_n = S_ACK_ST;
         S_ACK_ST:  if (send) state_n = S_HDR;
         default:   state_n = S_HDR;
      endcase
   end

   // State register, registered link/trace outputs and packet datapath
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state        <= S_HDR;
         rdy_r        <= 1'b0;
         v_r          <= 1'b0;
         trace_v_r    <= 1'b0;
         data_r       <= '0;
         err_r        <= 1'b0;
         src_cord_r   <= '0;
         rem_r        <= '0;
         idx_r        <= '0;
         trace_data_r <= '0;
         err_count_r  <= '0;
      end else begin
         state     <= state_n;
         rdy_r     <= (state_n == S_HDR) || (state_n == S_SRC) ||
                      (state_n == S_DATA) || (state_n == S_DRAIN);
         v_r       <= (state_n == S_ACK_HDR) || (state_n == S_ACK_ST);
         trace_v_r <= (state_n == S_OUT);

         if (state_n == S_ACK_HDR)
            data_r <= flit_width_p'({len_width_p'(1), ack_cord});
         else if (state_n == S_ACK_ST)
            data_r <= flit_width_p'(err_r);
         else
            data_r <= '0;

         case (state)
            S_HDR: begin
               if (accept && in_len != exp_len_lp) begin
                  err_r      <= 1'b1;
                  rem_r      <= in_len;
                  src_cord_r <= '0;
                  if (err_count_r != 8'hFF)
                     err_count_r <= err_count_r + 8'd1;
               end
            end
            S_SRC: begin
               if (accept) begin
                  src_cord_r <= in_cord;
                  idx_r      <= '0;
               end
            end
            S_DATA: begin
               if (accept) begin
                  trace_data_r[idx_r*flit_width_p +: flit_width_p] <= in_data;
                  idx_r <= idx_r + 1'b1;
               end
            end
            S_DRAIN: begin
               if (accept)
                  rem_r <= rem_r - 1'b1;
            end
            S_ACK_ST: begin
               if (send)
                  err_r <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign link_o       = {v_r, data_r, rdy_r};
   assign trace_v_o    = trace_v_r;
   assign trace_data_o = trace_data_r;
   assign err_count_o  = err_count_r;

endmodule

// File: tb/tb_bsg_util_tag_trace_depacketizer.sv
// tb/tb_bsg_util_tag_trace_depacketizer.sv - scoreboard bench for the tag-trace depacketizer
module tb_bsg_util_tag_trace_depacketizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_v, out_rdy, trace_ready;
   logic [7:0]  in_data;
   logic [9:0]  link_i, link_o;
   logic        trace_v;
   logic [31:0] trace_data;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_trace[$];
   logic [7:0]  exp_ack[$];
   logic [7:0]  nom[6];

   assign link_i = {in_v, in_data, out_rdy};

   bsg_util_tag_trace_depacketizer #(
      .flit_width_p(8), .cord_width_p(4), .len_width_p(4), .data_flits_p(4)
   ) dut (
      .clk_i        (clk),
      .reset_n_i    (rst_n),
      .link_i       (link_i),
      .link_o       (link_o),
      .trace_v_o    (trace_v),
      .trace_data_o (trace_data),
      .trace_ready_i(trace_ready),
      .err_count_o  (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a handshake will complete at the next edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (trace_v && trace_ready) begin
            if (exp_trace.size() == 0) begin
               checks++; errors++;
               $display("FAIL trace_unexpected: got %h expected none", trace_data);
            end else
               check("trace_word", trace_data, exp_trace.pop_front());
         end
         if (link_o[9] && link_i[0]) begin
            if (exp_ack.size() == 0) begin
               checks++; errors++;
               $display("FAIL ack_unexpected: got %h expected none", link_o[8:1]);
            end else
               check("ack_flit", {24'h0, link_o[8:1]}, {24'h0, exp_ack.pop_front()});
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit bubbles);
      int n;
      if (bubbles)
         while ($urandom_range(0, 1) == 1) begin
            in_v = 1'b0;
            @(posedge clk); #1;
         end
      in_v = 1'b1;
      in_data = d;
      n = 0;
      forever begin
         @(negedge clk);
         if (link_o[0]) begin
            @(posedge clk); #1;
            break;
         end
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: flit %h not accepted in 200 cycles, required acceptance", d);
            break;
         end
      end
      in_v = 1'b0;
      in_data = 8'hEE;
   endtask

   task automatic send_nominal(input bit bubbles);
      for (int i = 0; i < 6; i++) send(nom[i], bubbles);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      forever begin
         @(posedge clk); #1;
         if (exp_trace.size() == 0 && exp_ack.size() == 0 && link_o[0]) break;
         n++;
         if (n > 300) begin
            checks++; errors++;
            $display("FAIL idle_timeout: %0d traces %0d acks outstanding, required 0", exp_trace.size(), exp_ack.size());
            break;
         end
      end
   endtask

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      nom = '{8'h54, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
      rst_n = 1'b0; in_v = 1'b1; in_data = 8'h54; out_rdy = 1'b1; trace_ready = 1'b1;

      // Reset with link_i.v held high
      repeat (3) @(posedge clk);
      #1;
      check("reset_link_o", {22'h0, link_o}, 32'h0);
      check("reset_trace_v", {31'h0, trace_v}, 32'h0);
      check("reset_err_count", {24'h0, err_count}, 32'h0);
      check("reset_trace_data", trace_data, 32'h0);
      in_v = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Nominal packet, then trace and ack backpressure
      trace_ready = 1'b0;
      exp_trace.push_back(32'h44332211);
      exp_ack.push_back(8'h13);
      exp_ack.push_back(8'h00);
      send_nominal(1'b0);
      check("trace_latency", {31'h0, trace_v}, 32'h1);
      check("trace_data_out", trace_data, 32'h44332211);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("hold_trace_v", {31'h0, trace_v}, 32'h1);
         check("hold_trace_data", trace_data, 32'h44332211);
         check("hold_no_accept", {31'h0, link_o[0]}, 32'h0);
      end
      out_rdy = 1'b0;
      trace_ready = 1'b1;
      @(posedge clk); #1;
      trace_ready = 1'b0;
      check("ack_latency", {31'h0, link_o[9]}, 32'h1);
      check("trace_v_drop", {31'h0, trace_v}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("ack_hold_v", {31'h0, link_o[9]}, 32'h1);
         check("ack_hold_data", {24'h0, link_o[8:1]}, 32'h13);
      end
      out_rdy = 1'b1;
      trace_ready = 1'b1;
      wait_idle();
      check("err_count_nominal", {24'h0, err_count}, 32'h0);
      check("trace_data_after", trace_data, 32'h44332211);

      // Bad length 2: drain two flits
      exp_ack.push_back(8'h10);
      exp_ack.push_back(8'h01);
      send(8'h24, 1'b0);
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      wait_idle();
      check("err_count_len2", {24'h0, err_count}, 32'h1);

      // Length 0: ack immediately
      exp_ack.push_back(8'h10);
      exp_ack.push_back(8'h01);
      send(8'h04, 1'b0);
      wait_idle();
      check("err_count_len0", {24'h0, err_count}, 32'h2);

      // Nominal with bubbles; ack status shows err cleared
      exp_trace.push_back(32'h44332211);
      exp_ack.push_back(8'h13);
      exp_ack.push_back(8'h00);
      send_nominal(1'b1);
      wait_idle();
      check("err_count_bubbles", {24'h0, err_count}, 32'h2);

      // Mid-packet reset, then a full packet
      send(8'h54, 1'b0);
      send(8'h03, 1'b0);
      send(8'h11, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midrst_link_o", {22'h0, link_o}, 32'h0);
      check("midrst_trace_v", {31'h0, trace_v}, 32'h0);
      check("midrst_trace_data", trace_data, 32'h0);
      check("midrst_err_count", {24'h0, err_count}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_trace.push_back(32'h44332211);
      exp_ack.push_back(8'h13);
      exp_ack.push_back(8'h00);
      send_nominal(1'b0);
      wait_idle();
      repeat (5) @(posedge clk);
      #1;

      check("trace_queue_empty", exp_trace.size(), 32'h0);
      check("ack_queue_empty", exp_ack.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
